// File: rtl/traffic_lights_pkg.sv
// Shared types for the traffic light and its command sequencer:
// command codes, sequencer states and the light's time-register limits.
package traffic_lights_pkg;

    typedef enum logic [2:0] {
        CMD_ON         = 3'd0,
        CMD_OFF        = 3'd1,
        CMD_SERVICE    = 3'd2,
        CMD_SET_GREEN  = 3'd3,
        CMD_SET_RED    = 3'd4,
        CMD_SET_YELLOW = 3'd5
    } cmd_e;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_SERVICE,
        SEQ_SET_GREEN,
        SEQ_SET_RED,
        SEQ_SET_YELLOW,
        SEQ_START,
        SEQ_SINGLE,
        SEQ_GAP
    } seq_state_e;

    // Light time registers are 15 bits of 2 kHz ticks.
    localparam int unsigned TL_TIME_W      = 15;
    localparam int unsigned TL_TIME_MAX_MS = ((1 << TL_TIME_W) - 1) / 2;

endpackage

// File: rtl/traffic_cmd_sequencer.sv
// Command sequencer/arbiter in front of traffic_lights: turns a full timing
// config and on/off pulses into single-cycle cmd strobes for the light.
// Ports: clk_0m002/arst_n_i clock and async active-low reset;
//   cfg_val_i/cfg_ready_o + cfg_{green,red,yellow}_ms_i config handshake;
//   on_req_i/off_req_i request pulses; cmd_type_o/cmd_val_o/cmd_data_o to
//   the light; busy_o sequence in progress; err_o config rejected.
// Optional macro TRAFFIC_SEQ_RANGE_CHECK_EN: reject out-of-range configs.
module traffic_cmd_sequencer
    import traffic_lights_pkg::*;
#(
    parameter int unsigned CMD_GAP_CLK = 1,
    parameter int unsigned MIN_TIME_MS = 1,
    parameter int unsigned MAX_TIME_MS = 16383
) (
    input  logic        clk_0m002,
    input  logic        arst_n_i,
    input  logic        cfg_val_i,
    output logic        cfg_ready_o,
    input  logic [15:0] cfg_green_ms_i,
    input  logic [15:0] cfg_red_ms_i,
    input  logic [15:0] cfg_yellow_ms_i,
    input  logic        on_req_i,
    input  logic        off_req_i,
    output logic [2:0]  cmd_type_o,
    output logic        cmd_val_o,
    output logic [15:0] cmd_data_o,
    output logic        busy_o,
    output logic        err_o
);

    if (MIN_TIME_MS == 0 || MAX_TIME_MS > TL_TIME_MAX_MS ||
        MIN_TIME_MS > MAX_TIME_MS) begin : g_bad_param
        $error("traffic_cmd_sequencer: illegal time range");
    end

    localparam logic [15:0] GAP_LAST =
        (CMD_GAP_CLK == 0) ? 16'd0 : 16'(CMD_GAP_CLK - 1);

    seq_state_e  state_q, state_d;
    seq_state_e  ret_q, ret_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] green_q, green_d;
    logic [15:0] red_q, red_d;
    logic [15:0] yellow_q, yellow_d;
    cmd_e        single_q, single_d;
    logic        off_pend_q, off_pend_d;
    logic        on_pend_q, on_pend_d;
    logic        err_d;
    logic        cfg_bad;
    logic        adv;
    seq_state_e  adv_to;
    logic        off_any;
    logic        on_any;

`ifdef TRAFFIC_SEQ_RANGE_CHECK_EN
    logic err_q;

    function automatic logic out_of_range(input logic [15:0] v);
        return (32'(v) < MIN_TIME_MS) || (32'(v) > MAX_TIME_MS);
    endfunction

    assign cfg_bad = out_of_range(cfg_green_ms_i) |
                     out_of_range(cfg_red_ms_i) |
                     out_of_range(cfg_yellow_ms_i);
    assign err_o   = err_q;

    always_ff @(posedge clk_0m002 or negedge arst_n_i) begin
        if (!arst_n_i) err_q <= 1'b0;
        else           err_q <= err_d;
    end
`else
    assign cfg_bad = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign off_any = off_req_i | off_pend_q;
    assign on_any  = on_req_i | on_pend_q;
    assign busy_o  = (state_q != SEQ_IDLE);

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        gap_d       = gap_q;
        green_d     = green_q;
        red_d       = red_q;
        yellow_d    = yellow_q;
        single_d    = single_q;
        off_pend_d  = off_pend_q;
        on_pend_d   = on_pend_q;
        err_d       = 1'b0;
        adv         = 1'b0;
        adv_to      = SEQ_IDLE;
        cfg_ready_o = 1'b0;
        cmd_val_o   = 1'b0;
        cmd_type_o  = CMD_ON;
        cmd_data_o  = 16'd0;

        // Requests while busy are remembered and served back in IDLE.
        if (state_q != SEQ_IDLE) begin
            if (off_req_i) off_pend_d = 1'b1;
            if (on_req_i)  on_pend_d  = 1'b1;
        end

        unique case (state_q)
            SEQ_IDLE: begin
                cfg_ready_o = !off_any;
                if (off_any) begin
                    state_d    = SEQ_SINGLE;
                    single_d   = CMD_OFF;
                    off_pend_d = 1'b0;
                    on_pend_d  = 1'b0;
                end else if (cfg_val_i) begin
                    // An on pulse losing to the config is kept for later.
                    if (on_req_i) on_pend_d = 1'b1;
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        green_d  = cfg_green_ms_i;
                        red_d    = cfg_red_ms_i;
                        yellow_d = cfg_yellow_ms_i;
                        state_d  = SEQ_SERVICE;
                    end
                end else if (on_any) begin
                    state_d   = SEQ_SINGLE;
                    single_d  = CMD_ON;
                    on_pend_d = 1'b0;
                end
            end
            SEQ_SERVICE: begin
                cmd_val_o  = 1'b1;
                cmd_type_o = CMD_SERVICE;
                adv        = 1'b1;
                adv_to     = SEQ_SET_GREEN;
            end
            SEQ_SET_GREEN: begin
                cmd_val_o  = 1'b1;
                cmd_type_o = CMD_SET_GREEN;
                cmd_data_o = green_q;
                adv        = 1'b1;
                adv_to     = SEQ_SET_RED;
            end
            SEQ_SET_RED: begin
                cmd_val_o  = 1'b1;
                cmd_type_o = CMD_SET_RED;
                cmd_data_o = red_q;
                adv        = 1'b1;
                adv_to     = SEQ_SET_YELLOW;
            end
            SEQ_SET_YELLOW: begin
                cmd_val_o  = 1'b1;
                cmd_type_o = CMD_SET_YELLOW;
                cmd_data_o = yellow_q;
                adv        = 1'b1;
                adv_to     = SEQ_START;
            end
            SEQ_START: begin
                cmd_val_o  = 1'b1;
                cmd_type_o = CMD_ON;
                adv        = 1'b1;
                adv_to     = SEQ_IDLE;
            end
            SEQ_SINGLE: begin
                cmd_val_o  = 1'b1;
                cmd_type_o = single_q;
                adv        = 1'b1;
                adv_to     = SEQ_IDLE;
            end
            SEQ_GAP: begin
                if (gap_q == 16'd0) state_d = ret_q;
                else                gap_d   = gap_q - 16'd1;
            end
            default: state_d = SEQ_IDLE;
        endcase

        // Every command is followed by the gap; a zero gap skips it.
        if (adv) begin
            if (CMD_GAP_CLK == 0) begin
                state_d = adv_to;
            end else begin
                state_d = SEQ_GAP;
                ret_d   = adv_to;
                gap_d   = GAP_LAST;
            end
        end
    end

    always_ff @(posedge clk_0m002 or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= SEQ_IDLE;
            ret_q      <= SEQ_IDLE;
            gap_q      <= 16'd0;
            green_q    <= 16'd0;
            red_q      <= 16'd0;
            yellow_q   <= 16'd0;
            single_q   <= CMD_ON;
            off_pend_q <= 1'b0;
            on_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            gap_q      <= gap_d;
            green_q    <= green_d;
            red_q      <= red_d;
            yellow_q   <= yellow_d;
            single_q   <= single_d;
            off_pend_q <= off_pend_d;
            on_pend_q  <= on_pend_d;
        end
    end

endmodule

// File: tb/tb_traffic_cmd_sequencer.sv
// Directed scoreboard bench for traffic_cmd_sequencer (gap 1 and gap 0).
module tb_traffic_cmd_sequencer;

    typedef struct {
        int          cyc;
        logic [2:0]  typ;
        logic [15:0] dat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] green, red, yellow;
    logic        val_a, val_b;
    logic        on_a, off_a;
    logic        zero_b;
    logic        rdy_a, rdy_b;
    logic [2:0]  typ_a, typ_b;
    logic        cv_a, cv_b;
    logic [15:0] dat_a, dat_b;
    logic        busy_a, busy_b;
    logic        err_a, err_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    exp_t qa[$];
    exp_t qb[$];

    traffic_cmd_sequencer #(.CMD_GAP_CLK(1)) dut_a (
        .clk_0m002(clk), .arst_n_i(rst_n),
        .cfg_val_i(val_a), .cfg_ready_o(rdy_a),
        .cfg_green_ms_i(green), .cfg_red_ms_i(red),
        .cfg_yellow_ms_i(yellow),
        .on_req_i(on_a), .off_req_i(off_a),
        .cmd_type_o(typ_a), .cmd_val_o(cv_a), .cmd_data_o(dat_a),
        .busy_o(busy_a), .err_o(err_a)
    );

    traffic_cmd_sequencer #(.CMD_GAP_CLK(0)) dut_b (
        .clk_0m002(clk), .arst_n_i(rst_n),
        .cfg_val_i(val_b), .cfg_ready_o(rdy_b),
        .cfg_green_ms_i(green), .cfg_red_ms_i(red),
        .cfg_yellow_ms_i(yellow),
        .on_req_i(zero_b), .off_req_i(zero_b),
        .cmd_type_o(typ_b), .cmd_val_o(cv_b), .cmd_data_o(dat_b),
        .busy_o(busy_b), .err_o(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input bit b, input int c, input logic [2:0] ty,
                        input logic [15:0] d);
        exp_t e;
        e.cyc = c;
        e.typ = ty;
        e.dat = d;
        if (b) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    // Expected strobes of a config handshake at cycle t with gap g.
    task automatic push_seq(input bit b, input int t, input int g,
                            input logic [15:0] gr, input logic [15:0] rd,
                            input logic [15:0] ye);
        push(b, t + 1,         3'd2, 16'd0);
        push(b, t + 2 + g,     3'd3, gr);
        push(b, t + 3 + 2 * g, 3'd4, rd);
        push(b, t + 4 + 3 * g, 3'd5, ye);
        push(b, t + 5 + 4 * g, 3'd0, 16'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cv_a) begin
            chk("a_strobe_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_cycle", cyc, e.cyc);
                chk("a_type", 32'(typ_a), 32'(e.typ));
                chk("a_data", 32'(dat_a), 32'(e.dat));
            end
        end
        if (cv_b) begin
            chk("b_strobe_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_cycle", cyc, e.cyc);
                chk("b_type", 32'(typ_b), 32'(e.typ));
                chk("b_data", 32'(dat_b), 32'(e.dat));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_val"}, 32'(cv_a), 32'd0);
        chk({tag, "_type"}, 32'(typ_a), 32'd0);
        chk({tag, "_data"}, 32'(dat_a), 32'd0);
        chk({tag, "_busy"}, 32'(busy_a), 32'd0);
        chk({tag, "_err"}, 32'(err_a), 32'd0);
        chk({tag, "_ready"}, 32'(rdy_a), 32'd1);
    endtask

    task automatic drive_cfg(input logic [15:0] gr, input logic [15:0] rd,
                             input logic [15:0] ye);
        green  = gr;
        red    = rd;
        yellow = ye;
    endtask

    initial begin
        int t;
        rst_n  = 1'b0;
        val_a  = 1'b0;
        val_b  = 1'b0;
        on_a   = 1'b0;
        off_a  = 1'b0;
        zero_b = 1'b0;
        drive_cfg(16'd0, 16'd0, 16'd0);
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic config, gap 1.
        t = cyc;
        drive_cfg(16'd1000, 16'd2000, 16'd500);
        val_a = 1'b1;
        push_seq(0, t, 1, 16'd1000, 16'd2000, 16'd500);
        tick();
        val_a = 1'b0;
        chk("cfg1_busy", 32'(busy_a), 32'd1);
        chk("cfg1_ready_busy", 32'(rdy_a), 32'd0);
        wait_until(t + 10);
        chk("cfg1_ready_t10", 32'(rdy_a), 32'd0);
        tick();
        chk("cfg1_ready_t11", 32'(rdy_a), 32'd1);
        chk("cfg1_idle_t11", 32'(busy_a), 32'd0);
        chk("cfg1_idle_type", 32'(typ_a), 32'd0);

        // Off during a sequence is served after it completes.
        tick();
        t = cyc;
        drive_cfg(16'd3000, 16'd4000, 16'd1500);
        val_a = 1'b1;
        push_seq(0, t, 1, 16'd3000, 16'd4000, 16'd1500);
        push(0, t + 12, 3'd1, 16'd0);
        tick();
        val_a = 1'b0;
        wait_until(t + 4);
        off_a = 1'b1;
        tick();
        off_a = 1'b0;
        wait_until(t + 11);
        chk("offpend_ready_low", 32'(rdy_a), 32'd0);
        wait_until(t + 14);
        chk("offpend_idle", 32'(busy_a), 32'd0);
        chk("offpend_q_empty", qa.size(), 32'd0);

        // Simultaneous off and on in IDLE: only off.
        tick();
        t = cyc;
        off_a = 1'b1;
        on_a  = 1'b1;
        push(0, t + 1, 3'd1, 16'd0);
        tick();
        off_a = 1'b0;
        on_a  = 1'b0;
        wait_until(t + 6);
        chk("offon_idle", 32'(busy_a), 32'd0);
        chk("offon_q_empty", qa.size(), 32'd0);

        // Plain on request.
        tick();
        t = cyc;
        on_a = 1'b1;
        push(0, t + 1, 3'd0, 16'd0);
        tick();
        on_a = 1'b0;
        wait_until(t + 3);
        chk("on_idle_t3", 32'(busy_a), 32'd0);

        // Out-of-range red values.
        for (int k = 0; k < 2; k++) begin
            logic [15:0] rv;
            rv = (k == 0) ? 16'd0 : 16'd16384;
            tick();
            t = cyc;
            drive_cfg(16'd1000, rv, 16'd500);
            val_a = 1'b1;
`ifdef TRAFFIC_SEQ_RANGE_CHECK_EN
            tick();
            val_a = 1'b0;
            chk("range_err_pulse", 32'(err_a), 32'd1);
            chk("range_stay_idle", 32'(busy_a), 32'd0);
            chk("range_ready", 32'(rdy_a), 32'd1);
            tick();
            chk("range_err_clear", 32'(err_a), 32'd0);
            wait_until(t + 6);
`else
            push_seq(0, t, 1, 16'd1000, rv, 16'd500);
            tick();
            val_a = 1'b0;
            chk("norange_err", 32'(err_a), 32'd0);
            chk("norange_busy", 32'(busy_a), 32'd1);
            wait_until(t + 11);
            chk("norange_ready", 32'(rdy_a), 32'd1);
`endif
            chk("range_q_empty", qa.size(), 32'd0);
        end

        // Gap 0: five strobes back to back.
        tick();
        t = cyc;
        drive_cfg(16'd100, 16'd200, 16'd300);
        val_b = 1'b1;
        push_seq(1, t, 0, 16'd100, 16'd200, 16'd300);
        tick();
        val_b = 1'b0;
        wait_until(t + 5);
        chk("g0_ready_t5", 32'(rdy_b), 32'd0);
        tick();
        chk("g0_ready_t6", 32'(rdy_b), 32'd1);
        chk("g0_idle_t6", 32'(busy_b), 32'd0);
        chk("g0_q_empty", qb.size(), 32'd0);

        // Reset mid-sequence drops the rest.
        tick();
        t = cyc;
        drive_cfg(16'd1111, 16'd2222, 16'd333);
        val_a = 1'b1;
        push(0, t + 1, 3'd2, 16'd0);
        push(0, t + 3, 3'd3, 16'd1111);
        push(0, t + 5, 3'd4, 16'd2222);
        tick();
        val_a = 1'b0;
        wait_until(t + 5);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        chk("midreset_q_empty", qa.size(), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        t = cyc;
        drive_cfg(16'd1000, 16'd2000, 16'd500);
        val_a = 1'b1;
        push_seq(0, t, 1, 16'd1000, 16'd2000, 16'd500);
        tick();
        val_a = 1'b0;
        wait_until(t + 11);
        chk("postreset_ready", 32'(rdy_a), 32'd1);

        tick();
        tick();
        chk("final_qa_empty", qa.size(), 32'd0);
        chk("final_qb_empty", qb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
